// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD types and the per-decade next-value rule used by both the
// decade registers and the scanner's look-ahead.
package bcd_scan_counter_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_next(input bcd_digit_t d,
                                          input logic       carry_in,
                                          input logic       clr);
    bcd_digit_t r;
    if (clr)
      r = '0;
    else if (!carry_in)
      r = d;
    else if (d == BCD_MAX)
      r = '0;
    else
      r = d + bcd_digit_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One decimal decade: holds a 0..9 digit, increments on carry-in and
// propagates carry-out combinationally so a full ripple settles in one cycle.
module bcd_decade
  import bcd_scan_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      digit <= '0;
    else
      digit <= bcd_next(digit, carry_in, clear);
  end

  assign carry_out = carry_in & (digit == BCD_MAX);

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up-counter with a free-running one-hot digit scanner that
// presents one registered digit per cycle to the seven-segment decoder.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned COUNT_DIV  = 50000000,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  output logic [3:0]                bcd,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic [4*NUM_DIGITS-1:0]   count_bcd,
  output logic                      wrap
);

  localparam int unsigned CW = (COUNT_DIV  > 1) ? $clog2(COUNT_DIV)  : 1;
  localparam int unsigned SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0] cnt_pre;
  logic          cnt_tick;
  logic [SW-1:0] scan_pre;
  logic          scan_tick;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;

  logic [NUM_DIGITS:0]                 carry;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]    digit;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]    digit_nxt;
  logic [BCD_W-1:0]                    bcd_nxt;

  assign cnt_tick = en & (cnt_pre == CW'(COUNT_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_pre <= '0;
    else if (clear)
      cnt_pre <= '0;
    else if (en)
      cnt_pre <= cnt_tick ? '0 : cnt_pre + CW'(1);
  end

  assign carry[0] = cnt_tick;

  // digit_nxt mirrors each decade's register input so the output registers
  // can load post-edge values without an extra cycle of latency.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_decade
    bcd_decade u_decade (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .carry_in  (carry[i]),
      .digit     (digit[i]),
      .carry_out (carry[i+1])
    );
    assign digit_nxt[i] = bcd_next(digit[i], carry[i], clear);
  end

  assign count_bcd = digit;

  assign scan_tick = (scan_pre == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scan_pre <= '0;
    else
      scan_pre <= scan_tick ? '0 : scan_pre + SW'(1);
  end

  always_comb begin
    idx_nxt = idx;
    if (scan_tick)
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  if (NUM_DIGITS == 1) begin : g_one
    assign bcd_nxt = digit_nxt[0];
  end else begin : g_many
    assign bcd_nxt = digit_nxt[idx_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      bcd       <= '0;
      digit_sel <= NUM_DIGITS'(1);
      wrap      <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      bcd       <= bcd_nxt;
      digit_sel <= NUM_DIGITS'(1) << idx_nxt;
      wrap      <= cnt_tick & carry[NUM_DIGITS] & ~clear;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: a 4-digit build (COUNT_DIV=2), a
// COUNT_DIV=3 build for enable gating, and a single-digit build.
module tb_bcd_scan_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, en0 = 1'b0, clr0 = 1'b0;
  logic [3:0]  bcd0;
  logic [3:0]  sel0;
  logic [15:0] cnt0;
  logic        wrap0;

  logic        rst1 = 1'b1, en1 = 1'b0, clr1 = 1'b0;
  logic [3:0]  bcd1;
  logic [3:0]  sel1;
  logic [15:0] cnt1;
  logic        wrap1;

  logic        rst2 = 1'b1, en2 = 1'b0, clr2 = 1'b0;
  logic [3:0]  bcd2;
  logic [0:0]  sel2;
  logic [3:0]  cnt2;
  logic        wrap2;

  int tests = 0;
  int fails = 0;
  int edges0 = 0;
  bit mon_on = 1'b0;
  bit mon_bad;

  logic [3:0] exp_sel [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_bcd [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
  logic [15:0] exp_gate [12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h1, 16'h1,
                                 16'h1, 16'h1, 16'h1, 16'h1, 16'h2, 16'h2};

  bcd_scan_counter #(.NUM_DIGITS(4), .COUNT_DIV(2), .SCAN_DIV(3)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .clear(clr0),
    .bcd(bcd0), .digit_sel(sel0), .count_bcd(cnt0), .wrap(wrap0)
  );

  bcd_scan_counter #(.NUM_DIGITS(4), .COUNT_DIV(3), .SCAN_DIV(3)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .clear(clr1),
    .bcd(bcd1), .digit_sel(sel1), .count_bcd(cnt1), .wrap(wrap1)
  );

  bcd_scan_counter #(.NUM_DIGITS(1), .COUNT_DIV(2), .SCAN_DIV(3)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .clear(clr2),
    .bcd(bcd2), .digit_sel(sel2), .count_bcd(cnt2), .wrap(wrap2)
  );

  // Edges since dut0 left reset; its scan position is (edges0/3)%4.
  always @(posedge clk) edges0 <= rst0 ? 0 : edges0 + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      mon_bad = 1'b0;
      for (int i = 0; i < 4; i++)
        if (cnt0[4*i +: 4] > 4'd9) mon_bad = 1'b1;
      if (bcd0 > 4'd9 || cnt1[3:0] > 4'd9 || cnt1[7:4] > 4'd9 ||
          cnt1[11:8] > 4'd9 || cnt1[15:12] > 4'd9 || cnt2 > 4'd9)
        mon_bad = 1'b1;
      tests++;
      if (mon_bad) begin
        fails++;
        $display("FAIL digit_range: cnt0=%h bcd0=%h cnt1=%h cnt2=%h required every digit 0..9",
                 cnt0, bcd0, cnt1, cnt2);
      end
      tests++;
      if (!$onehot(sel0) || !$onehot(sel1) || sel2 !== 1'b1) begin
        fails++;
        $display("FAIL sel_onehot: sel0=%b sel1=%b sel2=%b required one-hot", sel0, sel1, sel2);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear0();
    en0 = 1'b0;
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
  endtask

  task automatic test_reset();
    en0 = 1'b1;
    step(7);
    tests++;
    if (cnt0 !== 16'h0003) begin
      fails++; $display("FAIL pre_reset_count: got %h expected %h", cnt0, 16'h0003);
    end
    #2 rst0 = 1'b1;
    #1;
    tests++;
    if (bcd0 !== 4'h0 || sel0 !== 4'b0001 || cnt0 !== 16'h0000 || wrap0 !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: bcd=%h sel=%b cnt=%h wrap=%b expected 0 0001 0000 0",
               bcd0, sel0, cnt0, wrap0);
    end
    step(2);
    rst0 = 1'b0;
    step(1);
    tests++;
    if (cnt0 !== 16'h0000 || sel0 !== 4'b0001) begin
      fails++; $display("FAIL post_reset_1: cnt=%h sel=%b expected 0000 0001", cnt0, sel0);
    end
    step(1);
    tests++;
    if (cnt0 !== 16'h0001 || sel0 !== 4'b0001 || bcd0 !== 4'd1) begin
      fails++; $display("FAIL first_inc: cnt=%h sel=%b bcd=%h expected 0001 0001 1", cnt0, sel0, bcd0);
    end
    en0 = 1'b0;
  endtask

  task automatic test_carry();
    clear0();
    tests++;
    if (cnt0 !== 16'h0000) begin
      fails++; $display("FAIL clear_idle: got %h expected 0000", cnt0);
    end
    en0 = 1'b1; step(18); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h0009) begin
      fails++; $display("FAIL reach_0009: got %h expected 0009", cnt0);
    end
    en0 = 1'b1; step(1);
    tests++;
    if (cnt0 !== 16'h0009) begin
      fails++; $display("FAIL hold_0009: got %h expected 0009", cnt0);
    end
    step(1); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h0010) begin
      fails++; $display("FAIL carry_0010: got %h expected 0010", cnt0);
    end
    clear0();
    en0 = 1'b1; step(1998); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h0999) begin
      fails++; $display("FAIL reach_0999: got %h expected 0999", cnt0);
    end
    en0 = 1'b1; step(2); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h1000) begin
      fails++; $display("FAIL carry_1000: got %h expected 1000", cnt0);
    end
  endtask

  task automatic test_rollover();
    clear0();
    en0 = 1'b1; step(19998); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h9999) begin
      fails++; $display("FAIL reach_9999: got %h expected 9999", cnt0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1);
      tests++;
      if (wrap0 !== 1'b0 || cnt0 !== 16'h9999) begin
        fails++; $display("FAIL hold_no_wrap: wrap=%b cnt=%h expected 0 9999", wrap0, cnt0);
      end
    end
    en0 = 1'b1; step(1);
    tests++;
    if (cnt0 !== 16'h9999 || wrap0 !== 1'b0) begin
      fails++; $display("FAIL pre_roll: cnt=%h wrap=%b expected 9999 0", cnt0, wrap0);
    end
    step(1); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h0000 || wrap0 !== 1'b1) begin
      fails++; $display("FAIL rollover: cnt=%h wrap=%b expected 0000 1", cnt0, wrap0);
    end
    step(1);
    tests++;
    if (cnt0 !== 16'h0000 || wrap0 !== 1'b0) begin
      fails++; $display("FAIL wrap_single: cnt=%h wrap=%b expected 0000 0", cnt0, wrap0);
    end
  endtask

  task automatic test_scan();
    clear0();
    en0 = 1'b1; step(8642); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h4321) begin
      fails++; $display("FAIL reach_4321: got %h expected 4321", cnt0);
    end
    for (int i = 0; i < 12; i++) begin
      if (edges0 % 12 == 0) break;
      step(1);
    end
    for (int j = 0; j < 15; j++) begin
      tests++;
      if (sel0 !== exp_sel[j/3] || bcd0 !== exp_bcd[j/3]) begin
        fails++;
        $display("FAIL scan[%0d]: sel=%b bcd=%h expected %b %h", j, sel0, bcd0, exp_sel[j/3], exp_bcd[j/3]);
      end
      step(1);
    end
  endtask

  task automatic test_clear_vs_tick();
    logic [3:0] es;
    clear0();
    en0 = 1'b1; step(19998);
    step(1);
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    es = 4'b0001 << ((edges0 / 3) % 4);
    tests++;
    if (cnt0 !== 16'h0000 || wrap0 !== 1'b0 || sel0 !== es) begin
      fails++;
      $display("FAIL clear_over_tick: cnt=%h wrap=%b sel=%b expected 0000 0 %b", cnt0, wrap0, sel0, es);
    end
    step(1);
    tests++;
    if (cnt0 !== 16'h0000 || wrap0 !== 1'b0) begin
      fails++; $display("FAIL clear_prescaler: cnt=%h wrap=%b expected 0000 0", cnt0, wrap0);
    end
    step(1); en0 = 1'b0;
    tests++;
    if (cnt0 !== 16'h0001) begin
      fails++; $display("FAIL after_clear_inc: got %h expected 0001", cnt0);
    end
  endtask

  task automatic test_en_gating();
    for (int k = 0; k < 12; k++) begin
      en1 = (k % 2 == 0);
      step(1);
      tests++;
      if (cnt1 !== exp_gate[k]) begin
        fails++; $display("FAIL en_gate[%0d]: got %h expected %h", k, cnt1, exp_gate[k]);
      end
    end
    en1 = 1'b0;
  endtask

  task automatic test_single_digit();
    en2 = 1'b1;
    step(18);
    tests++;
    if (cnt2 !== 4'd9 || bcd2 !== 4'd9 || wrap2 !== 1'b0 || sel2 !== 1'b1) begin
      fails++;
      $display("FAIL one_digit_9: cnt=%h bcd=%h wrap=%b sel=%b expected 9 9 0 1", cnt2, bcd2, wrap2, sel2);
    end
    step(2);
    en2 = 1'b0;
    tests++;
    if (cnt2 !== 4'd0 || bcd2 !== 4'd0 || wrap2 !== 1'b1) begin
      fails++; $display("FAIL one_digit_wrap: cnt=%h bcd=%h wrap=%b expected 0 0 1", cnt2, bcd2, wrap2);
    end
    step(1);
    tests++;
    if (wrap2 !== 1'b0 || sel2 !== 1'b1) begin
      fails++; $display("FAIL one_digit_after: wrap=%b sel=%b expected 0 1", wrap2, sel2);
    end
  endtask

  initial begin
    step(1);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    mon_on = 1'b1;
    test_reset();
    test_carry();
    test_rollover();
    test_scan();
    test_clear_vs_tick();
    test_en_gating();
    test_single_digit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit decimal (BCD) up-counter with a time-multiplexed digit scanner.
- Sits directly upstream of the seven-segment decoder: each cycle it presents one 4-bit BCD digit on `bcd` plus a one-hot digit-select.
- Board logic uses `digit_sel` to drive the common pins of a multiplexed display.
- The counter advances on a prescaled tick; the scanner rotates through the digits on its own prescaled tick.

Parameters:
- NUM_DIGITS, 4, number of BCD decades counted and scanned (legal 1..8).
- COUNT_DIV, 50000000, clk cycles per count increment while `en`=1 (legal >=1).
- SCAN_DIV, 50000, clk cycles each digit stays selected (legal >=1).

Ports:
- clk, input, 1, single system clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, count enable; when low, count prescaler and digits hold.
- clear, input, 1, synchronous clear of all digits and count prescaler.
- bcd, output, 4, BCD value of currently selected digit; feeds the decoder's bcd input.
- digit_sel, output, NUM_DIGITS, one-hot active-high; bit i selects digit i (digit 0 = least significant).
- count_bcd, output, 4*NUM_DIGITS, full registered count; digit i occupies bits [4i+3:4i].
- wrap, output, 1, one-cycle pulse when count rolls from all-9s to all-0s.

Behaviour:
- Reset (async assert, output values take effect immediately):
  - all digits = 0, both prescalers = 0, scan index = 0;
  - bcd = 4'h0, digit_sel = one-hot bit 0, count_bcd = 0, wrap = 0.
- Count prescaler:
  - Increments each clk while en=1.
  - At COUNT_DIV-1, the next cycle it returns to 0 and issues one count tick.
  - Holds its value while en=0.
  - COUNT_DIV=1 gives a tick every enabled cycle.
- Count tick:
  - Digit 0 increments.
  - A digit at 9 with carry-in goes to 0 and carries to the next digit.
  - Ripple completes within the same cycle; all digits update on the same edge.
- Digit range:
  - Every digit is always in 0..9.
  - Values 10..15 are never produced: the downstream decoder blanks them, so any such value is a bug.
- Rollover and wrap:
  - Carry out of the top digit wraps the count to all zeros.
  - wrap = 1 for exactly the cycle following that update edge (registered).
- clear:
  - Next edge sets all digits and the count prescaler to 0.
  - Overrides a simultaneous tick; no wrap is generated.
  - Scan prescaler and scan index are unaffected.
- Scan:
  - Scan prescaler runs free, independent of en and clear.
  - At SCAN_DIV-1 it returns to 0 and the index advances.
  - Index wraps NUM_DIGITS-1 -> 0.
  - NUM_DIGITS=1: index stays 0.
- Output registers:
  - bcd, digit_sel and count_bcd are registered.
  - On each edge, bcd <= digit[index_next] and digit_sel <= onehot(index_next), using post-edge digit and index values.
  - bcd and digit_sel therefore always change together and never show a mismatched pair.
  - Latency: a digit change is visible on count_bcd and, if that digit is selected, on bcd in the same cycle as the digit register.
- Invariant: exactly one digit_sel bit is high at all times, including during and immediately after reset.
- Reset mid-operation clears everything asynchronously. After deassertion, counting resumes from 0 after a full COUNT_DIV period, and scanning starts at digit 0.

Decomposition:
- Shared package:
  - BCD_MAX = 4'd9;
  - BCD width constant = 4;
  - typedef bcd_digit_t (logic [3:0]).
- One natural sub-module, bcd_decade:
  - inputs: clk, rst, clear, carry_in;
  - outputs: digit (4 bits), carry_out (= carry_in & digit==9);
  - generated NUM_DIGITS times.
- Prescalers and scanner stay in the top level.

Test Plan (NUM_DIGITS=4, COUNT_DIV=2, SCAN_DIV=3 unless stated):
- Reset: assert rst mid-run -> immediately bcd=0, digit_sel=4'b0001, count_bcd=16'h0000, wrap=0. After release, first increment to 16'h0001 occurs 2 cycles after en=1.
- BCD carry: count 16'h0009, one tick -> 16'h0010. From 16'h0999 -> 16'h1000. No digit ever 10..15; check on every cycle.
- Rollover: preload via ticks to 16'h9999, one tick -> 16'h0000 and wrap high exactly one cycle. Hold 16'h9999 with en=0 -> wrap never pulses.
- Scan: count 16'h4321, en=0 -> digit_sel sequence 0001,0010,0100,1000,0001 with each held 3 cycles, and bcd 1,2,3,4,1 aligned to it.
- clear vs tick: assert clear on the cycle a tick is due at 16'h9999 -> count 16'h0000, wrap=0, scan position undisturbed.
- en gating: toggle en every other cycle with COUNT_DIV=3 -> increment only after 3 enabled cycles accumulated. NUM_DIGITS=1 build: digit_sel constant 1'b1, count 9 -> 0 with wrap.
